div: RTL

DIV -- requirements
Module: div

---
 rtl/div.sv | 107 ++++++++++
 1 files changed

// File: rtl/div.sv
// div: 32-bit signed/unsigned restoring radix-2 divider, one quotient bit per cycle.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);
    typedef enum logic [1:0] {DivFree, DivByZero, DivOn, DivEnd} state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt, cnt_nxt;
    logic [64:0] dividend, dividend_nxt;
    logic [31:0] divisor, divisor_nxt;
    logic        neg_q, neg_q_nxt, neg_r, neg_r_nxt;
    logic [63:0] result_nxt;
    logic        ready_nxt;
    logic [64:0] shifted;
    logic [32:0] trial;
    logic [31:0] quo, rem;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= DivFree;
            cnt      <= '0;
            dividend <= '0;
            divisor  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            dividend <= dividend_nxt;
            divisor  <= divisor_nxt;
            neg_q    <= neg_q_nxt;
            neg_r    <= neg_r_nxt;
            result_o <= result_nxt;
            ready_o  <= ready_nxt;
        end
    end

    // dividend holds {partial remainder[32:0], quotient/unshifted dividend[31:0]};
    // the remainder stays below the divisor, so the 33-bit trial borrow is exact
    always_comb begin
        shifted      = dividend << 1;
        trial        = shifted[64:32] - {1'b0, divisor};
        quo          = neg_q ? -dividend[31:0] : dividend[31:0];
        rem          = neg_r ? -dividend[63:32] : dividend[63:32];
        state_nxt    = state;
        cnt_nxt      = cnt;
        dividend_nxt = dividend;
        divisor_nxt  = divisor;
        neg_q_nxt    = neg_q;
        neg_r_nxt    = neg_r;
        result_nxt   = result_o;
        ready_nxt    = ready_o;
        case (state)
            DivFree: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == 32'd0) begin
                        state_nxt = DivByZero;
                    end else begin
                        state_nxt    = DivOn;
                        cnt_nxt      = '0;
                        dividend_nxt = {33'd0, (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i};
                        divisor_nxt  = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
                        neg_q_nxt    = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                        neg_r_nxt    = signed_div_i && opdata1_i[31];
                    end
                end
            end
            DivByZero: begin
                state_nxt  = DivEnd;
                result_nxt = '0;
                ready_nxt  = 1'b1;
            end
            DivOn: begin
                if (annul_i) begin
                    state_nxt  = DivFree;
                    result_nxt = '0;
                    ready_nxt  = 1'b0;
                end else if (cnt != 6'd32) begin
                    dividend_nxt = trial[32] ? shifted : {trial, shifted[31:1], 1'b1};
                    cnt_nxt      = cnt + 6'd1;
                end else begin
                    state_nxt  = DivEnd;
                    result_nxt = {rem, quo};
                    ready_nxt  = 1'b1;
                end
            end
            DivEnd: begin
                if (!start_i) begin
                    state_nxt  = DivFree;
                    result_nxt = '0;
                    ready_nxt  = 1'b0;
                end
            end
            default: state_nxt = DivFree;
        endcase
    end
endmodule
